// File: rtl/cb_branch_ctrl.sv
// cb_branch_ctrl: branch handshake controller for one B-stage of the pipeline.
// It accepts one token on the upstream Send/Ack channel and pulses CB_CP so the
// stage datapath latches the packet. It then steers the token to output channel
// a or b, as chosen by BR, and holds at most one token at a time.
//
// Input FSM
//   state     | meaning
//   IN_IDLE   | waiting for CB_Send_in while the output side is empty
//   IN_ACK    | token accepted, CB_Ack_out high until CB_Send_in returns to zero
// Output FSM
//   state     | meaning
//   OUT_EMPTY | no token held (the CB_CP cycle still counts as empty)
//   OUT_SEND  | selected Send_out high, waiting for its Ack_in
//   OUT_RTZ   | Send_out dropped, waiting for the selected Ack_in to fall
module cb_branch_ctrl (
  input  logic CLK,
  input  logic MR,
  input  logic CB_Send_in,
  input  logic BR,
  input  logic CB_Ack_in_a,
  input  logic CB_Ack_in_b,
  output logic CB_Ack_out,
  output logic CB_Send_out_a,
  output logic CB_Send_out_b,
  output logic CB_CP
);

  typedef enum logic {
    IN_IDLE,
    IN_ACK
  } in_state_t;

  typedef enum logic [1:0] {
    OUT_EMPTY,
    OUT_SEND,
    OUT_RTZ
  } out_state_t;

  in_state_t  in_state, in_nxt;
  out_state_t out_state, out_nxt;
  logic       br_q, br_nxt;
  logic       ack_out_nxt, send_a_nxt, send_b_nxt, cp_nxt;
  logic       sel_ack;

  // Only the acknowledge of the channel the held token was steered to matters.
  assign sel_ack = br_q ? CB_Ack_in_b : CB_Ack_in_a;

  // Next-state and next-output logic for both FSMs. Every output is registered.
  always_comb begin
    in_nxt      = in_state;
    out_nxt     = out_state;
    br_nxt      = br_q;
    ack_out_nxt = CB_Ack_out;
    send_a_nxt  = CB_Send_out_a;
    send_b_nxt  = CB_Send_out_b;
    cp_nxt      = 1'b0;

    case (in_state)
      IN_IDLE: begin
        // The registered OUT_EMPTY gates the accept. A token is therefore taken
        // no earlier than the cycle after OUT_EMPTY is re-entered.
        if (CB_Send_in && (out_state == OUT_EMPTY)) begin
          in_nxt      = IN_ACK;
          ack_out_nxt = 1'b1;
          cp_nxt      = 1'b1;
          br_nxt      = BR;
        end
      end
      IN_ACK: begin
        if (!CB_Send_in) begin
          in_nxt      = IN_IDLE;
          ack_out_nxt = 1'b0;
        end
      end
      default: begin
        in_nxt      = IN_IDLE;
        ack_out_nxt = 1'b0;
      end
    endcase

    case (out_state)
      OUT_EMPTY: begin
        // The datapath captures on the edge that ends the CB_CP cycle. The token
        // becomes visible downstream on that same edge.
        if (CB_CP) begin
          out_nxt    = OUT_SEND;
          send_a_nxt = ~br_q;
          send_b_nxt = br_q;
        end
      end
      OUT_SEND: begin
        if (sel_ack) begin
          out_nxt    = OUT_RTZ;
          send_a_nxt = 1'b0;
          send_b_nxt = 1'b0;
        end
      end
      OUT_RTZ: begin
        if (!sel_ack) begin
          out_nxt = OUT_EMPTY;
        end
      end
      default: begin
        out_nxt    = OUT_EMPTY;
        send_a_nxt = 1'b0;
        send_b_nxt = 1'b0;
      end
    endcase
  end

  // State and output registers. A synchronous reset drops any in-flight token.
  always_ff @(posedge CLK) begin
    if (!MR) begin
      in_state      <= IN_IDLE;
      out_state     <= OUT_EMPTY;
      br_q          <= 1'b0;
      CB_Ack_out    <= 1'b0;
      CB_Send_out_a <= 1'b0;
      CB_Send_out_b <= 1'b0;
      CB_CP         <= 1'b0;
    end else begin
      in_state      <= in_nxt;
      out_state     <= out_nxt;
      br_q          <= br_nxt;
      CB_Ack_out    <= ack_out_nxt;
      CB_Send_out_a <= send_a_nxt;
      CB_Send_out_b <= send_b_nxt;
      CB_CP         <= cp_nxt;
    end
  end

endmodule

// File: tb/tb_cb_branch_ctrl.sv
// Directed testbench for cb_branch_ctrl. Inputs change and outputs are sampled
// 1 ns after each rising edge.
module tb_cb_branch_ctrl;

  logic CLK = 1'b0;
  logic MR, CB_Send_in, BR, CB_Ack_in_a, CB_Ack_in_b;
  logic CB_Ack_out, CB_Send_out_a, CB_Send_out_b, CB_CP;

  int n_cmp = 0;
  int n_err = 0;

  cb_branch_ctrl dut (
    .CLK          (CLK),
    .MR           (MR),
    .CB_Send_in   (CB_Send_in),
    .BR           (BR),
    .CB_Ack_in_a  (CB_Ack_in_a),
    .CB_Ack_in_b  (CB_Ack_in_b),
    .CB_Ack_out   (CB_Ack_out),
    .CB_Send_out_a(CB_Send_out_a),
    .CB_Send_out_b(CB_Send_out_b),
    .CB_CP        (CB_CP)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Watchdog for the whole run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int        cp_cnt;
    int        both_cnt;
    int        n_rise;
    int        idx;
    logic [2:0] order;
    logic [2:0] br_list;
    logic       prev_a, prev_b;

    // 1: reset with every input high
    MR = 1'b0; CB_Send_in = 1'b1; BR = 1'b1; CB_Ack_in_a = 1'b1; CB_Ack_in_b = 1'b1;
    tick(); tick();
    chk("rst_ack_out", CB_Ack_out, 0);
    chk("rst_send_a", CB_Send_out_a, 0);
    chk("rst_send_b", CB_Send_out_b, 0);
    chk("rst_cp", CB_CP, 0);
    MR = 1'b1;
    tick();
    chk("rel_cp", CB_CP, 1);
    chk("rel_ack_out", CB_Ack_out, 1);
    CB_Send_in = 1'b0; CB_Ack_in_a = 1'b0; CB_Ack_in_b = 1'b0;
    tick();
    chk("rel_cp_once", CB_CP, 0);
    chk("rel_send_b", CB_Send_out_b, 1);
    chk("rel_send_a", CB_Send_out_a, 0);
    chk("rel_ack_rtz", CB_Ack_out, 0);
    CB_Ack_in_b = 1'b1;
    tick();
    chk("rel_send_b_drop", CB_Send_out_b, 0);
    CB_Ack_in_b = 1'b0;
    tick(); tick();

    // 2: route a
    BR = 1'b0; CB_Send_in = 1'b1;
    tick();
    chk("a_cp", CB_CP, 1);
    chk("a_ack_out", CB_Ack_out, 1);
    chk("a_send_early", CB_Send_out_a, 0);
    tick();
    chk("a_cp_off", CB_CP, 0);
    chk("a_send_a", CB_Send_out_a, 1);
    chk("a_send_b", CB_Send_out_b, 0);
    chk("a_ack_hold", CB_Ack_out, 1);
    CB_Send_in = 1'b0;
    tick();
    chk("a_ack_rtz", CB_Ack_out, 0);
    chk("a_send_hold", CB_Send_out_a, 1);
    CB_Ack_in_a = 1'b1;
    tick();
    chk("a_send_drop", CB_Send_out_a, 0);
    CB_Ack_in_a = 1'b0;
    tick();

    // 3: route b, with stray pulses on Ack_in_a
    BR = 1'b1; CB_Send_in = 1'b1;
    tick();
    chk("b_cp", CB_CP, 1);
    CB_Send_in = 1'b0; CB_Ack_in_a = 1'b1;
    tick();
    chk("b_send_b", CB_Send_out_b, 1);
    chk("b_send_a", CB_Send_out_a, 0);
    CB_Ack_in_a = 1'b0;
    tick();
    CB_Ack_in_a = 1'b1;
    tick();
    chk("b_ignore_ack_a", CB_Send_out_b, 1);
    CB_Ack_in_a = 1'b0; CB_Ack_in_b = 1'b1;
    tick();
    chk("b_send_drop", CB_Send_out_b, 0);
    CB_Ack_in_b = 1'b0;
    tick();

    // 4: back-pressure on channel b while a new request waits upstream
    BR = 1'b1; CB_Send_in = 1'b1;
    tick();
    chk("bp_cp", CB_CP, 1);
    CB_Send_in = 1'b0;
    tick();
    chk("bp_send_b", CB_Send_out_b, 1);
    CB_Send_in = 1'b1; BR = 1'b0;
    cp_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (CB_CP || CB_Ack_out || !CB_Send_out_b) cp_cnt++;
    end
    chk("bp_stall", cp_cnt[7:0], 0);
    CB_Ack_in_b = 1'b1;
    tick();
    chk("bp_send_drop", CB_Send_out_b, 0);
    chk("bp_rtz_cp", CB_CP, 0);
    CB_Ack_in_b = 1'b0;
    tick();
    chk("bp_wait_empty_cp", CB_CP, 0);
    chk("bp_wait_empty_ack", CB_Ack_out, 0);
    tick();
    chk("bp_accept_cp", CB_CP, 1);
    chk("bp_accept_ack", CB_Ack_out, 1);
    CB_Send_in = 1'b0;
    tick();
    chk("bp_send_a", CB_Send_out_a, 1);
    CB_Ack_in_a = 1'b1;
    tick();
    CB_Ack_in_a = 1'b0;
    tick(); tick();

    // 5: back-to-back tokens a, b, a with acks that follow Send_out immediately
    br_list = 3'b010;
    idx = 0; cp_cnt = 0; both_cnt = 0; n_rise = 0; order = 3'b000;
    prev_a = 1'b0; prev_b = 1'b0;
    for (int c = 0; c < 80; c++) begin
      if (CB_CP) cp_cnt++;
      if (CB_Send_out_a && CB_Send_out_b) both_cnt++;
      if ((CB_Send_out_a && !prev_a) || (CB_Send_out_b && !prev_b)) begin
        if (n_rise < 3) order[n_rise] = CB_Send_out_b;
        n_rise++;
      end
      prev_a = CB_Send_out_a;
      prev_b = CB_Send_out_b;
      if (CB_Send_in && CB_Ack_out) begin
        CB_Send_in = 1'b0;
        idx++;
      end else if (!CB_Send_in && !CB_Ack_out && idx < 3) begin
        CB_Send_in = 1'b1;
        BR = br_list[idx];
      end
      CB_Ack_in_a = CB_Send_out_a;
      CB_Ack_in_b = CB_Send_out_b;
      tick();
    end
    chk("b2b_cp_count", cp_cnt[7:0], 3);
    chk("b2b_rise_count", n_rise[7:0], 3);
    chk("b2b_order", {5'd0, order}, 8'd2);
    chk("b2b_never_both", both_cnt[7:0], 0);
    CB_Send_in = 1'b0; CB_Ack_in_a = 1'b0; CB_Ack_in_b = 1'b0;
    tick(); tick();

    // 6: reset while in OUT_SEND on channel a
    BR = 1'b0; CB_Send_in = 1'b1;
    tick();
    chk("rs_cp", CB_CP, 1);
    CB_Send_in = 1'b0;
    tick();
    chk("rs_send_a", CB_Send_out_a, 1);
    MR = 1'b0;
    tick();
    chk("rs_send_a_clr", CB_Send_out_a, 0);
    chk("rs_ack_clr", CB_Ack_out, 0);
    chk("rs_cp_clr", CB_CP, 0);
    MR = 1'b1; BR = 1'b1; CB_Send_in = 1'b1;
    tick();
    chk("rs_next_cp", CB_CP, 1);
    chk("rs_next_ack", CB_Ack_out, 1);
    CB_Send_in = 1'b0;
    tick();
    chk("rs_next_send_b", CB_Send_out_b, 1);
    chk("rs_next_send_a", CB_Send_out_a, 0);
    CB_Ack_in_b = 1'b1;
    tick();
    chk("rs_next_drop", CB_Send_out_b, 0);
    CB_Ack_in_b = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
